// File: rtl/fpu_pkg.sv
// Shared constants and state encoding for the 16-bit FPU mantissa datapath.
package fpu_pkg;

  localparam int WIDTH      = 13;
  localparam int EXP_W      = 5;
  localparam int HIDDEN_BIT = WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mant_sub_norm_ripple_sub.sv
// Combinational ripple subtractor: a + ~b + 1 through a chain of full-adder cells.
module ripple_sub #(
  parameter int WIDTH = 13
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] b_n;

  assign carry[0] = 1'b1;
  assign b_n      = ~b;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign diff[i]      = a[i] ^ b_n[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b_n[i]) | (carry[i] & (a[i] ^ b_n[i]));
  end

  // No carry out of the top cell means the subtraction borrowed (a < b).
  assign borrow = ~carry[WIDTH];

endmodule

// File: rtl/mant_sub_norm.sv
// Multi-cycle mantissa subtract (|a-b|) and one-bit-per-cycle left normalizer.
module mant_sub_norm
  import fpu_pkg::*;
#(
  parameter int WIDTH = fpu_pkg::WIDTH,
  parameter int EXP_W = fpu_pkg::EXP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [EXP_W-1:0] exp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic [EXP_W-1:0] exp_out,
  output logic             neg,
  output logic             zero,
  output logic             underflow
);

  localparam int               HID       = WIDTH - 2;
  localparam logic [WIDTH-1:0] LOAD_MASK = {1'b0, {(WIDTH-1){1'b1}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, mag_q, mag_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             neg_q, neg_d, zero_q, zero_d, uf_q, uf_d;

  logic [WIDTH-1:0] sub_diff, mag_abs;
  logic             sub_borrow;

  ripple_sub #(.WIDTH(WIDTH)) u_sub (
    .a      (a_q),
    .b      (b_q),
    .diff   (sub_diff),
    .borrow (sub_borrow)
  );

  assign mag_abs = sub_borrow ? ({WIDTH{1'b0}} - sub_diff) : sub_diff;

  always_comb begin
    // NOTE: every _d gets a hold default before the case so no path infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    uf_d    = uf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a & LOAD_MASK;
          b_d     = b & LOAD_MASK;
          exp_d   = exp_in;
          mag_d   = '0;
          neg_d   = 1'b0;
          zero_d  = 1'b0;
          uf_d    = 1'b0;
          state_d = SUB;
        end
      end
      SUB: begin
        if (mag_abs == '0) begin
          zero_d  = 1'b1;
          mag_d   = '0;
          exp_d   = '0;
          neg_d   = 1'b0;
          state_d = DONE;
        end else begin
          mag_d   = mag_abs;
          neg_d   = sub_borrow;
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_q[HID]) begin
          state_d = DONE;
        end else if (exp_q == '0) begin
          // Denormal: exponent exhausted, leave the magnitude unshifted.
          uf_d    = 1'b1;
          state_d = DONE;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments; reset clears datapath too so outputs read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mag_q   <= '0;
      exp_q   <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      uf_q    <= uf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = mag_q;
  assign exp_out   = exp_q;
  assign neg       = neg_q;
  assign zero      = zero_q;
  assign underflow = uf_q;

endmodule

// File: tb/tb_mant_sub_norm.sv
// Directed bench for mant_sub_norm: hand-computed vectors, latency, backpressure, reset abort.
module tb_mant_sub_norm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [12:0] a, b;
  logic [4:0]  exp_in;
  logic        out_valid, out_ready;
  logic [12:0] diff;
  logic [4:0]  exp_out;
  logic        neg, zero, underflow;

  int total = 0;
  int bad   = 0;

  mant_sub_norm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .exp_out   (exp_out),
    .neg       (neg),
    .zero      (zero),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands for one edge (E0), then count edges until out_valid.
  task automatic start_and_wait(input logic [12:0] av, input logic [12:0] bv,
                                input logic [4:0] ev, output int lat);
    @(negedge clk);
    check("in_ready_before_load", 32'(in_ready), 32'd1);
    a = av; b = bv; exp_in = ev; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic check_result(input string tag, input int lat, input int exp_lat,
                              input logic [12:0] d, input logic [4:0] e,
                              input logic n, input logic z, input logic u);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_diff"}, 32'(diff), 32'(d));
    check({tag, "_exp_out"}, 32'(exp_out), 32'(e));
    check({tag, "_flags"}, {29'd0, neg, zero, underflow}, {29'd0, n, z, u});
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_consumed"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; exp_in = '0;
    #12;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_outputs", {12'd0, out_valid, diff, exp_out, neg, zero, underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // No shift needed: 0xC00-0x400 = 0x800 already normalized.
    start_and_wait(13'h0C00, 13'h0400, 5'd15, lat);
    check_result("pos_noshift", lat, 2, 13'h0800, 5'd15, 1'b0, 1'b0, 1'b0);
    // Backpressure: five cycles with out_ready low, result must not move.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_state", {12'd0, out_valid, in_ready, diff, exp_out, neg},
            {12'd0, 1'b1, 1'b0, 13'h0800, 5'd15, 1'b0});
    end
    release_result("pos_noshift");

    start_and_wait(13'h0400, 13'h0C00, 5'd15, lat);
    check_result("neg_noshift", lat, 2, 13'h0800, 5'd15, 1'b1, 1'b0, 1'b0);
    release_result("neg_noshift");

    // Bit 12 of each operand is masked on load, so this equals the first case.
    start_and_wait(13'h1C00, 13'h1400, 5'd15, lat);
    check_result("masked_msb", lat, 2, 13'h0800, 5'd15, 1'b0, 1'b0, 1'b0);
    release_result("masked_msb");

    // Maximum normalization: magnitude 1 shifted 11 times.
    start_and_wait(13'h0801, 13'h0800, 5'd20, lat);
    check_result("max_shift", lat, 13, 13'h0800, 5'd9, 1'b0, 1'b0, 1'b0);
    release_result("max_shift");

    // Zero result, with out_ready raised before out_valid (must not short-cut).
    out_ready = 1'b1;
    start_and_wait(13'h0A55, 13'h0A55, 5'd7, lat);
    check_result("zero", lat, 1, 13'h0000, 5'd0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("zero_consumed", 32'(out_valid), 32'd0);

    // Exponent exhausted after 3 shifts: 1 -> 8, denormal.
    start_and_wait(13'h0801, 13'h0800, 5'd3, lat);
    check_result("underflow", lat, 5, 13'h0008, 5'd0, 1'b0, 1'b0, 1'b1);
    release_result("underflow");

    // Negative with shifts: 0x0300-0x0500 = -0x200, 2 shifts -> 0x800, exp 8.
    start_and_wait(13'h0300, 13'h0500, 5'd10, lat);
    check_result("neg_shift", lat, 4, 13'h0800, 5'd8, 1'b1, 1'b0, 1'b0);
    release_result("neg_shift");

    // Abort: reset lands in the middle of a long NORM sequence.
    @(negedge clk);
    a = 13'h0801; b = 13'h0800; exp_in = 5'd20; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_outputs", {12'd0, out_valid, diff, exp_out, neg, zero, underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_after_release", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});

    start_and_wait(13'h0C00, 13'h0400, 5'd15, lat);
    check_result("post_abort", lat, 2, 13'h0800, 5'd15, 1'b0, 1'b0, 1'b0);
    release_result("post_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
